// File: rtl/qspi_arb_pkg.sv
// Shared types and helpers for the QSPI engine arbiter (qspi_arb).
package qspi_arb_pkg;

    localparam int unsigned MEM_BITS_DEF = 7;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIRd   = 3'd1,
        StDWr   = 3'd2,
        StDRd   = 3'd3,
        StFault = 3'd4
    } arb_state_e;

    // Line tag width: physical address minus the byte-in-line offset bits.
    function automatic int unsigned tag_width(input int unsigned pa, input int unsigned line_len);
        return pa - $clog2(line_len);
    endfunction

endpackage

// File: rtl/qspi_arb_wdog.sv
// Transfer watchdog: counts cycles while enabled, flags expiry on the TIMEOUT-th cycle.
module qspi_arb_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire = en && !clr && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qspi_arb.sv
// Shares the QSPI line engine between icache fills and dcache push/pull.
// Define QSPI_ARB_RR_EN for round-robin on simultaneous requests; default is dcache priority.
module qspi_arb
    import qspi_arb_pkg::*;
#(
    parameter int unsigned PA          = 22,
    parameter int unsigned LINE_LENGTH = 4,
    parameter int unsigned MEM_BITS    = MEM_BITS_DEF,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   i_pull,
    input  logic [tag_width(PA, LINE_LENGTH)-1:0]  i_tag,
    input  logic                                   d_push,
    input  logic                                   d_pull,
    input  logic [tag_width(PA, LINE_LENGTH)-1:0]  d_tag,
    input  logic                                   q_done,
    output logic                                   q_req,
    output logic                                   q_i_d,
    output logic                                   q_write,
    output logic                                   q_mem,
    output logic [tag_width(PA, LINE_LENGTH)-1:0]  q_paddr,
    output logic                                   i_grant,
    output logic                                   d_grant,
    output logic                                   i_done,
    output logic                                   d_done,
    output logic                                   q_fault
);

    localparam int unsigned TW = tag_width(PA, LINE_LENGTH);

    arb_state_e    state_q, state_d;
    logic          gap_q, gap_d;
    logic [TW-1:0] paddr_q, paddr_d;
    logic          mem_q, mem_d;
    logic          wd_clr, wd_expire;
    logic          want_d, d_wins;
`ifdef QSPI_ARB_RR_EN
    logic          last_data_q, last_data_d;
`endif

    assign want_d = d_push | d_pull;

`ifdef QSPI_ARB_RR_EN
    // On a tie the side that did not win last time goes first.
    assign d_wins = want_d && !(i_pull && last_data_q);
`else
    assign d_wins = want_d;
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = 1'b0;
        paddr_d = paddr_q;
        mem_d   = mem_q;
        wd_clr  = 1'b0;
`ifdef QSPI_ARB_RR_EN
        last_data_d = last_data_q;
`endif
        case (state_q)
            StIdle: begin
                if (d_wins) begin
                    state_d = d_push ? StDWr : StDRd;
                    paddr_d = d_tag;
                    mem_d   = &d_tag[TW-1 -: MEM_BITS];
                    wd_clr  = 1'b1;
`ifdef QSPI_ARB_RR_EN
                    last_data_d = 1'b1;
`endif
                end else if (i_pull) begin
                    state_d = StIRd;
                    paddr_d = i_tag;
                    mem_d   = &i_tag[TW-1 -: MEM_BITS];
                    wd_clr  = 1'b1;
`ifdef QSPI_ARB_RR_EN
                    last_data_d = 1'b0;
`endif
                end
            end
            StIRd: begin
                if (q_done) begin
                    state_d = StIdle;
                end else if (wd_expire) begin
                    state_d = StFault;
                end
            end
            StDWr: begin
                if (q_done) begin
                    if (d_pull) begin
                        // Stay locked to dcache; q_req drops for the single gap cycle.
                        state_d = StDRd;
                        gap_d   = 1'b1;
                        paddr_d = d_tag;
                        mem_d   = &d_tag[TW-1 -: MEM_BITS];
                        wd_clr  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (wd_expire) begin
                    state_d = StFault;
                end
            end
            StDRd: begin
                if (!gap_q) begin
                    if (q_done) begin
                        state_d = StIdle;
                    end else if (wd_expire) begin
                        state_d = StFault;
                    end
                end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            gap_q   <= 1'b0;
            paddr_q <= '0;
            mem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            paddr_q <= paddr_d;
            mem_q   <= mem_d;
        end
    end

`ifdef QSPI_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`endif

    assign q_req   = (state_q == StIRd) || (state_q == StDWr) || ((state_q == StDRd) && !gap_q);
    assign q_i_d   = (state_q == StIRd);
    assign q_write = (state_q == StDWr);
    assign q_mem   = mem_q;
    assign q_paddr = paddr_q;
    assign i_grant = (state_q == StIRd);
    assign d_grant = (state_q == StDWr) || (state_q == StDRd);
    assign q_fault = (state_q == StFault);
    assign i_done  = (state_q == StIRd) && q_done;
    assign d_done  = q_done && (((state_q == StDRd) && !gap_q) || ((state_q == StDWr) && !d_pull));

    qspi_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (q_req),
        .expire (wd_expire)
    );

endmodule

// File: tb/tb_qspi_arb.sv
// Self-checking bench for qspi_arb: directed scenarios plus randomized requests vs a reference model.
module tb_qspi_arb;

    localparam int TW      = 20;
    localparam int TIMEOUT = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_pull = 1'b0, d_push = 1'b0, d_pull = 1'b0, q_done = 1'b0;
    logic [TW-1:0] i_tag = '0, d_tag = '0;
    logic          q_req, q_i_d, q_write, q_mem, i_grant, d_grant, i_done, d_done, q_fault;
    logic [TW-1:0] q_paddr;

    int n_vec = 0;
    int n_err = 0;
    bit last_data = 1'b1;

    always #5 clk = ~clk;

    qspi_arb #(
        .PA          (22),
        .LINE_LENGTH (4),
        .MEM_BITS    (7),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_pull  (i_pull),
        .i_tag   (i_tag),
        .d_push  (d_push),
        .d_pull  (d_pull),
        .d_tag   (d_tag),
        .q_done  (q_done),
        .q_req   (q_req),
        .q_i_d   (q_i_d),
        .q_write (q_write),
        .q_mem   (q_mem),
        .q_paddr (q_paddr),
        .i_grant (i_grant),
        .d_grant (d_grant),
        .i_done  (i_done),
        .d_done  (d_done),
        .q_fault (q_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference arbitration: 0 none, 1 icache fill, 2 dcache push, 3 dcache pull.
    function automatic int pick(input bit ip, input bit dpu, input bit dpl, input bit ld);
        bit dw;
`ifdef QSPI_ARB_RR_EN
        dw = (dpu || dpl) && !(ip && ld);
`else
        dw = dpu || dpl;
`endif
        if (dw) return dpu ? 2 : 3;
        if (ip) return 1;
        return 0;
    endfunction

    task automatic exp_xfer(input int kind, input logic [TW-1:0] tag, input string nm);
        chk({nm, "_req"}, q_req, 1);
        chk({nm, "_i_d"}, q_i_d, kind == 1);
        chk({nm, "_write"}, q_write, kind == 2);
        chk({nm, "_paddr"}, q_paddr, tag);
        chk({nm, "_mem"}, q_mem, (tag >> 13) == 7'h7F);
        chk({nm, "_igrant"}, i_grant, kind == 1);
        chk({nm, "_dgrant"}, d_grant, kind != 1);
    endtask

    task automatic finish_xfer(input int kind, input int dly, input bit pull_after, input string nm);
        repeat (dly) begin
            chk({nm, "_hold_req"}, q_req, 1);
            chk({nm, "_hold_done"}, {i_done, d_done}, 2'b00);
            tick();
        end
        q_done = 1'b1;
        if (kind == 2) d_pull = pull_after;
        #1;
        chk({nm, "_idone"}, i_done, kind == 1);
        chk({nm, "_ddone"}, d_done, (kind == 3) || (kind == 2 && !pull_after));
        if (kind == 1) begin
            i_pull = 1'b0;
        end else if (kind == 2 && pull_after) begin
            d_push = 1'b0;
        end else begin
            d_push = 1'b0;
            d_pull = 1'b0;
        end
        tick();
        q_done = 1'b0;
    endtask

    task automatic gap_check(input string nm);
        chk({nm, "_gap_req"}, q_req, 0);
        chk({nm, "_gap_dgrant"}, d_grant, 1);
        chk({nm, "_gap_igrant"}, i_grant, 0);
        chk({nm, "_gap_ddone"}, d_done, 0);
    endtask

    initial begin
        int k;
        // Reset state
        tick();
        chk("rst_req", q_req, 0);
        chk("rst_outs", {q_i_d, q_write, q_mem, i_grant, d_grant, i_done, d_done, q_fault}, 0);
        chk("rst_paddr", q_paddr, 0);
        reset = 1'b1;
        tick();

        // Stray q_done while idle
        q_done = 1'b1;
        #1;
        chk("idle_qdone", {i_done, d_done}, 2'b00);
        tick();
        q_done = 1'b0;
        chk("idle_req", q_req, 0);

        // Icache fill to RAM region, one-cycle grant latency
        i_pull = 1'b1;
        i_tag  = 20'hFFFF0;
        #1;
        chk("t1_latency", q_req, 0);
        tick();
        last_data = 1'b0;
        exp_xfer(1, 20'hFFFF0, "t1");
        finish_xfer(1, 2, 0, "t1");

        // Push then pull, icache arriving mid-pair waits for d_done
        d_push = 1'b1;
        d_pull = 1'b1;
        d_tag  = 20'h00120;
        tick();
        last_data = 1'b1;
        exp_xfer(2, 20'h00120, "t2");
        i_pull = 1'b1;
        i_tag  = 20'h12345;
        finish_xfer(2, 3, 1, "t2");
        gap_check("t2");
        tick();
        exp_xfer(3, 20'h00120, "t2rd");
        finish_xfer(3, 2, 0, "t2rd");
        tick();
        last_data = 1'b0;
        exp_xfer(1, 20'h12345, "t4");
        finish_xfer(1, 1, 0, "t4");

        // Simultaneous icache/dcache pull, twice in a row
        for (int r = 0; r < 2; r++) begin
            i_pull = 1'b1;
            d_pull = 1'b1;
            i_tag  = 20'h0AAAA;
            d_tag  = 20'h05555;
            k = pick(1'b1, 1'b0, 1'b1, last_data);
            last_data = (k != 1);
            tick();
            exp_xfer(k, (k == 1) ? i_tag : d_tag, "t3");
            finish_xfer(k, 1, 0, "t3");
            i_pull = 1'b0;
            d_pull = 1'b0;
        end

        // Randomized requests against the reference model
        for (int it = 0; it < 40; it++) begin
            bit ip, dpu, dpl, pa;
            ip  = 1'($urandom_range(0, 1));
            dpu = 1'($urandom_range(0, 1));
            dpl = 1'($urandom_range(0, 1));
            if (!(ip || dpu || dpl)) ip = 1'b1;
            i_pull = ip;
            d_push = dpu;
            d_pull = dpl;
            i_tag  = TW'($urandom);
            d_tag  = TW'($urandom);
            if ($urandom_range(0, 3) == 0) i_tag[TW-1 -: 7] = 7'h7F;
            if ($urandom_range(0, 3) == 0) d_tag[TW-1 -: 7] = 7'h7F;
            #1;
            chk("rnd_latency", q_req, 0);
            k = pick(ip, dpu, dpl, last_data);
            last_data = (k != 1);
            tick();
            exp_xfer(k, (k == 1) ? i_tag : d_tag, "rnd");
            // Requester withdrawing mid-transfer must not cancel it
            if ($urandom_range(0, 1) == 1) begin
                if (k == 1) i_pull = 1'b0;
                else if (k == 2) d_push = 1'b0;
                else d_pull = 1'b0;
            end
            pa = (k == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            finish_xfer(k, $urandom_range(0, 6), pa, "rnd");
            if (pa) begin
                if ($urandom_range(0, 1) == 1) i_pull = 1'b1;
                gap_check("rnd");
                tick();
                exp_xfer(3, d_tag, "rndrd");
                finish_xfer(3, $urandom_range(0, 4), 0, "rndrd");
            end
        end
        i_pull = 1'b0;
        d_push = 1'b0;
        d_pull = 1'b0;
        tick();

        // Reset in the middle of an icache fill
        i_pull = 1'b1;
        i_tag  = 20'h0ABCD;
        tick();
        exp_xfer(1, 20'h0ABCD, "t6");
        tick();
        reset = 1'b0;
        #1;
        chk("t6_rst_req", q_req, 0);
        chk("t6_rst_outs", {q_i_d, q_mem, i_grant, d_grant, q_fault}, 0);
        chk("t6_rst_paddr", q_paddr, 0);
        last_data = 1'b1;
        tick();
        chk("t6_held_req", q_req, 0);
        reset = 1'b1;
        tick();
        last_data = 1'b0;
        exp_xfer(1, 20'h0ABCD, "t6re");
        finish_xfer(1, 1, 0, "t6re");

        // Timeout: transfer outstanding for TIMEOUT cycles
        d_pull = 1'b1;
        d_tag  = 20'h00777;
        tick();
        exp_xfer(3, 20'h00777, "t5");
        d_pull = 1'b0;
        repeat (TIMEOUT - 1) tick();
        chk("t5_last_req", q_req, 1);
        chk("t5_not_yet", q_fault, 0);
        tick();
        chk("t5_fault", q_fault, 1);
        chk("t5_req_drop", q_req, 0);
        chk("t5_grants", {i_grant, d_grant}, 2'b00);
        i_pull = 1'b1;
        d_push = 1'b1;
        q_done = 1'b1;
        #1;
        chk("t5_qdone_ign", {i_done, d_done}, 2'b00);
        tick();
        q_done = 1'b0;
        repeat (5) tick();
        chk("t5_no_grant", {q_req, i_grant, d_grant}, 3'b000);
        chk("t5_sticky", q_fault, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
